// File: rtl/sample_frame_buffer.sv
// rtl/sample_frame_buffer.sv - multi-channel circular frame buffer between sample source and mixer
// Frames fill channel by channel; only committed frames are visible to the reader.
module sample_frame_buffer #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int OVERWRITE = 0,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int FR_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [CH_W-1:0]   in_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_chan,
  output logic              out_last,
  output logic [FR_W-1:0]   frames,
  output logic              overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(DEPTH * CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [FR_W-1:0] FULL    = FR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH*CHANNELS];
  logic [PW-1:0]     wr_frm, rd_frm;
  logic [CH_W-1:0]   wr_ch, rd_ch;
  logic [FR_W-1:0]   frame_cnt;
  logic              ovf;
  logic              accept, commit, pop, final_pop, drop;
  logic [AW-1:0]     wr_addr, rd_addr;

  assign in_ready  = (OVERWRITE != 0) ? 1'b1 : (frame_cnt < FULL);
  assign accept    = in_valid & in_ready & ~flush;
  assign commit    = accept & (wr_ch == LAST_CH);
  assign out_valid = (frame_cnt != '0);
  assign out_last  = (rd_ch == LAST_CH);
  assign pop       = out_valid & out_ready & ~flush;
  assign final_pop = pop & out_last;
  // Starting a new frame over a full store reuses the oldest slot, so that frame is discarded.
  assign drop      = (OVERWRITE != 0) & accept & (wr_ch == '0) & (frame_cnt == FULL) & ~final_pop;

  assign wr_addr  = AW'(wr_frm) * AW'(CHANNELS) + AW'(wr_ch);
  assign rd_addr  = AW'(rd_frm) * AW'(CHANNELS) + AW'(rd_ch);
  assign out_data = mem[rd_addr];
  assign in_chan  = wr_ch;
  assign out_chan = rd_ch;
  assign frames   = frame_cnt;
  assign overflow = ovf;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_frm    <= '0;
      wr_ch     <= '0;
      rd_frm    <= '0;
      rd_ch     <= '0;
      frame_cnt <= '0;
      ovf       <= 1'b0;
    end else if (flush) begin
      wr_frm    <= '0;
      wr_ch     <= '0;
      rd_frm    <= '0;
      rd_ch     <= '0;
      frame_cnt <= '0;
      ovf       <= 1'b0;
    end else begin
      if (commit) begin
        wr_ch  <= '0;
        wr_frm <= wr_frm + 1'b1;
      end else if (accept) begin
        wr_ch <= wr_ch + 1'b1;
      end
      // A drop aborts any partially read frame as well as retiring the oldest one.
      if (drop || final_pop) begin
        rd_ch  <= '0;
        rd_frm <= rd_frm + 1'b1;
      end else if (pop) begin
        rd_ch <= rd_ch + 1'b1;
      end
      case ({commit, final_pop | drop})
        2'b10:   frame_cnt <= frame_cnt + 1'b1;
        2'b01:   frame_cnt <= frame_cnt - 1'b1;
        default: frame_cnt <= frame_cnt;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

endmodule
